rr_arbiter4: RTL

Round-robin arbiter that shares a single resource among four requesting agents. It replaces fixed-priority granting with rotating fairness. A grant is held until the owner releases its request or, optionally, until a maximum tenure expires. It sits between the agents' request lines and the shared resource's select and enable logic.

---
 rtl/rr_arbiter4_pkg.sv | 15 +
 rtl/rr_arbiter4_pick.sv | 43 ++++
 rtl/rr_arbiter4.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-agent round-robin arbiter.
// The arbiter top and the rotating picker both import this package.
package arb_pkg;

  localparam int NUM_REQ = 4;

  // Reset leaves the pointer on agent 3, so agent 0 is first in line afterwards.
  localparam logic [1:0] LAST_RST = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational rotating-priority picker: searches last+1, last+2, last+3, last
// and reports the first requesting agent as an index and as a one-hot vector.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         pick,
  output logic [NUM_REQ-1:0] pick_oh
);

  logic [NUM_REQ-1:0] rot_req;
  logic [1:0]         offset;

  // rot_req[0] is the agent just after the pointer, rot_req[3] is the pointer itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      localparam logic [1:0] STEP = 2'(gi + 1);
      assign rot_req[gi] = req[last + STEP];
    end
  endgenerate

  always_comb begin
    offset = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        offset = 2'(i);
      end
    end
  end

  assign found = |req;
  assign pick  = last + offset + 2'd1;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_oh
      assign pick_oh[gi] = found && (pick == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arbiter4.sv
// Four-agent round-robin arbiter with hold-until-release grants.
// Define RR_ARBITER4_TIMEOUT_EN to force release after MAX_TENURE grant cycles.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_TENURE = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               timeout
);

  generate
    if (MAX_TENURE < 2 || MAX_TENURE > 256) begin : g_bad_tenure
      $error("rr_arbiter4: MAX_TENURE must lie in 2..256");
    end
  endgenerate

  arb_state_t         state_reg, state_next;
  logic [1:0]         last_reg, last_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [1:0]         gnt_id_reg, gnt_id_next;
  logic               busy_reg;
  logic               owner_req;
  logic               expire;

  logic               pick_found;
  logic [1:0]         pick_idx;
  logic [NUM_REQ-1:0] pick_oh;

  rr_pick u_pick (
    .req     (req),
    .last    (last_reg),
    .found   (pick_found),
    .pick    (pick_idx),
    .pick_oh (pick_oh)
  );

  // gnt_id_reg always names the owner while in HOLD.
  assign owner_req = req[gnt_id_reg];

`ifdef RR_ARBITER4_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(MAX_TENURE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TENURE - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg;

  // A simultaneous release wins over expiry, so expiry needs the request still up.
  assign expire = (state_reg == HOLD) && owner_req && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE) begin
      if (pick_found) begin
        cnt_next = '0;
      end
    end else if (owner_req && (cnt_reg != CNT_LAST)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= expire;
    end
  end

  assign timeout = timeout_reg;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    gnt_next    = gnt_reg;
    gnt_id_next = gnt_id_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next  = HOLD;
          last_next   = pick_idx;
          gnt_next    = pick_oh;
          gnt_id_next = pick_idx;
        end
      end
      HOLD: begin
        // Leaving HOLD always passes through IDLE, so transfers never go back-to-back.
        if (!owner_req || expire) begin
          state_next  = IDLE;
          gnt_next    = '0;
          gnt_id_next = 2'd0;
        end
      end
      default: begin
        state_next  = IDLE;
        gnt_next    = '0;
        gnt_id_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      last_reg   <= LAST_RST;
      gnt_reg    <= '0;
      gnt_id_reg <= 2'd0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      gnt_reg    <= gnt_next;
      gnt_id_reg <= gnt_id_next;
      busy_reg   <= |gnt_next;
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = busy_reg;

endmodule
